// File: rtl/eca_pkg.sv
// Shared types and constants for the elementary cellular-automaton engine.
package eca_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int RULE_W = 8;

    localparam logic [RULE_W-1:0] RULE_30  = 8'd30;
    localparam logic [RULE_W-1:0] RULE_90  = 8'd90;
    localparam logic [RULE_W-1:0] RULE_110 = 8'd110;
    localparam logic [RULE_W-1:0] RULE_184 = 8'd184;

endpackage

// File: rtl/eca_cell_update.sv
// Combinational next-generation function: every cell looks up rule_r with its
// {left, centre, right} = {q[i+1], q[i], q[i-1]} neighbourhood.
module eca_cell_update
    import eca_pkg::*;
#(
    parameter int WIDTH = 512
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [RULE_W-1:0] rule_r,
    input  logic              wrap_r,
    output logic [WIDTH-1:0]  q_next
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic l, c, r;

        // Edge cells see the opposite edge only in toroidal mode, else 0.
        if (i == WIDTH - 1) begin : g_top
            assign l = wrap_r & q[0];
        end else begin : g_mid_l
            assign l = q[i+1];
        end

        if (i == 0) begin : g_bot
            assign r = wrap_r & q[WIDTH-1];
        end else begin : g_mid_r
            assign r = q[i-1];
        end

        assign c         = q[i];
        assign q_next[i] = rule_r[{l, c, r}];
    end

endmodule

// File: rtl/eca_engine.sv
// Run-time programmable elementary CA engine: single step, N-generation burst
// or free-run, with busy/done handshake.
module eca_engine
    import eca_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  data,
    input  logic [RULE_W-1:0] rule,
    input  logic              wrap,
    input  logic              start,
    input  logic [CNT_W-1:0]  steps,
    input  logic              step,
    input  logic              stop,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  gen_count
);

    state_t            state, state_next;
    logic [RULE_W-1:0] rule_r, upd_rule;
    logic              wrap_r, upd_wrap;
    logic [CNT_W-1:0]  target, gen_inc;
    logic [WIDTH-1:0]  q_next;
    logic              do_load, do_start, do_step, do_run, do_stop, run_end;

    // A single step uses the rule/wrap presented on that same edge, so the
    // update function sees the live inputs in IDLE and the latched ones in RUN.
    assign upd_rule = (state == IDLE) ? rule : rule_r;
    assign upd_wrap = (state == IDLE) ? wrap : wrap_r;

    eca_cell_update #(.WIDTH(WIDTH)) u_update (
        .q      (q),
        .rule_r (upd_rule),
        .wrap_r (upd_wrap),
        .q_next (q_next)
    );

    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_start   = 1'b0;
        do_step    = 1'b0;
        do_run     = 1'b0;
        do_stop    = 1'b0;
        run_end    = 1'b0;
        gen_inc    = gen_count + CNT_W'(1);
        case (state)
            IDLE: begin
                // stop outranks start/step even though it has no effect here
                if (load) begin
                    do_load = 1'b1;
                end else if (stop) begin
                    do_stop = 1'b0;
                end else if (start) begin
                    do_start   = 1'b1;
                    state_next = RUN;
                end else if (step) begin
                    do_step = 1'b1;
                end
            end
            RUN: begin
                if (load) begin
                    do_load    = 1'b1;
                    state_next = IDLE;
                end else if (stop) begin
                    do_stop    = 1'b1;
                    state_next = IDLE;
                end else begin
                    do_run = 1'b1;
                    if ((target != '0) && (gen_inc == target)) begin
                        run_end    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gen_count <= '0;
            rule_r    <= '0;
            wrap_r    <= 1'b0;
            target    <= '0;
        end else begin
            busy <= (state_next == RUN);
            done <= 1'b0;
            if (do_load) begin
                q         <= data;
                gen_count <= '0;
            end
            if (do_start) begin
                rule_r    <= rule;
                wrap_r    <= wrap;
                target    <= steps;
                gen_count <= '0;
            end
            if (do_step) begin
                rule_r    <= rule;
                wrap_r    <= wrap;
                q         <= q_next;
                gen_count <= CNT_W'(1);
                done      <= 1'b1;
            end
            // Free-run relies on gen_inc wrapping naturally at 2^CNT_W.
            if (do_run) begin
                q         <= q_next;
                gen_count <= gen_inc;
                done      <= run_end;
            end
            if (do_stop) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eca_engine.sv
// Directed bench for eca_engine: 16-cell instance with hand-computed vectors
// plus a 512-cell rule-30 smoke run against a software model.
module tb_eca_engine;
    import eca_pkg::*;

    localparam int W  = 16;
    localparam int BW = 512;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          load, wrap, start, step, stop;
    logic [W-1:0]  data;
    logic [7:0]    rule;
    logic [CW-1:0] steps;
    logic [W-1:0]  q;
    logic          busy, done;
    logic [CW-1:0] gen_count;

    logic          b_load, b_wrap, b_start, b_step, b_stop;
    logic [BW-1:0] b_data, b_q;
    logic [7:0]    b_rule;
    logic [CW-1:0] b_steps, b_gen;
    logic          b_busy, b_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    eca_engine #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .load(load), .data(data), .rule(rule),
        .wrap(wrap), .start(start), .steps(steps), .step(step), .stop(stop),
        .q(q), .busy(busy), .done(done), .gen_count(gen_count)
    );

    eca_engine #(.WIDTH(BW), .CNT_W(CW)) dut_wide (
        .clk(clk), .reset(reset), .load(b_load), .data(b_data), .rule(b_rule),
        .wrap(b_wrap), .start(b_start), .steps(b_steps), .step(b_step), .stop(b_stop),
        .q(b_q), .busy(b_busy), .done(b_done), .gen_count(b_gen)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] model_gen(input logic [BW-1:0] s, input logic [7:0] rl);
        logic [BW-1:0] n;
        logic l, r;
        for (int i = 0; i < BW; i++) begin
            l = (i == BW - 1) ? 1'b0 : s[i+1];
            r = (i == 0) ? 1'b0 : s[i-1];
            n[i] = rl[{l, s[i], r}];
        end
        return n;
    endfunction

    task automatic do_load(input logic [W-1:0] v);
        data = v; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total++; if (q !== 16'h0)    begin bad++; $display("FAIL reset_q got=%h exp=0000", q); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (gen_count !== 16'd0) begin bad++; $display("FAIL reset_gen got=%0d exp=0", gen_count); end
    endtask

    task automatic test_single_step();
        do_load(16'h0100);
        total++; if (q !== 16'h0100 || done !== 1'b0) begin bad++; $display("FAIL step_load q=%h done=%b exp q=0100 done=0", q, done); end
        rule = RULE_90; wrap = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        total++; if (q !== 16'h0280) begin bad++; $display("FAIL step_q got=%h exp=0280", q); end
        total++; if (gen_count !== 16'd1) begin bad++; $display("FAIL step_gen got=%0d exp=1", gen_count); end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL step_done done=%b busy=%b exp done=1 busy=0", done, busy); end
        tick();
        total++; if (done !== 1'b0 || q !== 16'h0280) begin bad++; $display("FAIL step_after done=%b q=%h exp done=0 q=0280", done, q); end
    endtask

    task automatic test_boundary();
        do_load(16'h0001);
        rule = RULE_90; wrap = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        total++; if (q !== 16'h0002) begin bad++; $display("FAIL bound_zero got=%h exp=0002", q); end
        do_load(16'h0001);
        wrap = 1'b1; step = 1'b1;
        tick();
        step = 1'b0; wrap = 1'b0;
        total++; if (q !== 16'h8002) begin bad++; $display("FAIL bound_wrap got=%h exp=8002", q); end
    endtask

    // Bursts of 3 rule-30 generations from 0x0100: 0380, 0640, 0DE0.
    task automatic run_burst30(input string nm, input logic mid_noise);
        int nb;
        do_load(16'h0100);
        rule = RULE_30; wrap = 1'b0; steps = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || q !== 16'h0100 || gen_count !== 16'd0) begin bad++; $display("FAIL %s_start busy=%b q=%h gen=%0d exp busy=1 q=0100 gen=0", nm, busy, q, gen_count); end
        if (mid_noise) begin
            rule = RULE_90; wrap = 1'b1; step = 1'b1;
        end
        nb = 1;
        for (int k = 0; k < 10 && busy; k++) begin
            tick();
            if (busy) nb++;
        end
        step = 1'b0;
        total++; if (nb !== 3 || busy !== 1'b0) begin bad++; $display("FAIL %s_busy cycles=%0d busy=%b exp cycles=3 busy=0", nm, nb, busy); end
        total++; if (q !== 16'h0DE0) begin bad++; $display("FAIL %s_q got=%h exp=0de0", nm, q); end
        total++; if (gen_count !== 16'd3 || done !== 1'b1) begin bad++; $display("FAIL %s_end gen=%0d done=%b exp gen=3 done=1", nm, gen_count, done); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse got=%b exp=0", nm, done); end
    endtask

    task automatic test_burst();
        run_burst30("burst", 1'b0);
    endtask

    task automatic test_free_run();
        logic [W-1:0] exp_q [5];
        exp_q = '{16'h00E8, 16'h00D4, 16'h00AA, 16'h0055, 16'h002A};
        do_load(16'h00F0);
        rule = RULE_184; wrap = 1'b0; steps = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (q !== exp_q[k] || busy !== 1'b1) begin bad++; $display("FAIL free_gen%0d q=%h busy=%b exp q=%h busy=1", k + 1, q, busy, exp_q[k]); end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL free_stop busy=%b done=%b exp busy=0 done=1", busy, done); end
        total++; if (gen_count !== 16'd5 || q !== 16'h002A) begin bad++; $display("FAIL free_hold gen=%0d q=%h exp gen=5 q=002a", gen_count, q); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL free_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_abort_load();
        do_load(16'h0100);
        rule = RULE_30; steps = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        data = 16'hAAAA; load = 1'b1;
        tick();
        load = 1'b0;
        total++; if (q !== 16'hAAAA || busy !== 1'b0) begin bad++; $display("FAIL abort_load q=%h busy=%b exp q=aaaa busy=0", q, busy); end
        total++; if (done !== 1'b0 || gen_count !== 16'd0) begin bad++; $display("FAIL abort_load_flags done=%b gen=%0d exp done=0 gen=0", done, gen_count); end
        tick();
        total++; if (done !== 1'b0 || q !== 16'hAAAA) begin bad++; $display("FAIL abort_load_after done=%b q=%h exp done=0 q=aaaa", done, q); end
    endtask

    task automatic test_abort_reset();
        do_load(16'h0100);
        rule = RULE_90; steps = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (q !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'd0) begin bad++; $display("FAIL abort_reset q=%h busy=%b done=%b gen=%0d exp all zero", q, busy, done, gen_count); end
    endtask

    task automatic test_ignored();
        run_burst30("midrule", 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++; if (q !== 16'h0DE0 || gen_count !== 16'd3 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL idle_stop q=%h gen=%0d busy=%b done=%b exp q=0de0 gen=3 busy=0 done=0", q, gen_count, busy, done); end
    endtask

    task automatic test_wide();
        logic [BW-1:0] m;
        bit got;
        m = '0;
        m[BW/2] = 1'b1;
        b_data = m; b_load = 1'b1;
        tick();
        b_load = 1'b0;
        b_rule = RULE_30; b_wrap = 1'b0; b_steps = 16'd64; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            tick();
            got = b_done;
        end
        for (int k = 0; k < 64; k++) m = model_gen(m, RULE_30);
        total++; if (!got) begin bad++; $display("FAIL wide_done timeout exp done within 100 cycles"); end
        total++; if (b_q !== m) begin bad++; $display("FAIL wide_q got=%h exp=%h", b_q, m); end
        total++; if (b_gen !== 16'd64) begin bad++; $display("FAIL wide_gen got=%0d exp=64", b_gen); end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; wrap = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0;
        data = '0; rule = '0; steps = '0;
        b_load = 1'b0; b_wrap = 1'b0; b_start = 1'b0; b_step = 1'b0; b_stop = 1'b0;
        b_data = '0; b_rule = '0; b_steps = '0;
        test_reset();
        test_single_step();
        test_boundary();
        test_burst();
        test_free_run();
        test_abort_load();
        test_abort_reset();
        test_ignored();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
